saturating_counter_bank: RTL and testbench
==========================================

Name: saturating_counter_bank

Overview:
Multi-channel saturating counter bank, successor to the single-channel saturating counter used for mood/stimulus state. Each channel supports variable step size, per-channel set, optional periodic decay toward a rest value and a hysteresis "high" flag. Sits between the stimulus decoders and the mood/state logic; one instance replaces several single-channel counters.

Parameters:
N, 8, counter width per channel (bits)
CH, 4, number of channels
STEP_W, 3, width of the shared step input
DEFAULT_VAL, 2, value loaded into every channel on reset
SET_VAL, 0, value loaded when the channel's setval is asserted
REST_VAL, 2, decay target value
DECAY_DIV, 16, clk cycles between decay ticks (>=2)
HI_TH, 200, high flag set threshold (value >= HI_TH)
LO_TH, 50, high flag clear threshold (value <= LO_TH); LO_TH < HI_TH required

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
inc  input  CH  per-channel increment request
dec  input  CH  per-channel decrement request
setval  input  CH  per-channel synchronous load of SET_VAL
step  input  STEP_W  step magnitude shared by all channels
decay_en  input  1  enables the decay prescaler
value  output  CH*N  channel values packed; channel k at [k*N +: N]
at_max  output  CH  value == 2^N-1 (combinational from value)
at_min  output  CH  value == 0 (combinational from value)
high  output  CH  registered hysteresis flag
sat_evt  output  CH  registered one-cycle pulse on a clipped inc/dec

Behaviour:
- Reset (async, rst_n low): every value = DEFAULT_VAL; high = 1 if DEFAULT_VAL >= HI_TH else 0; sat_evt = 0; prescaler = 0.
- Per-channel priority each edge: setval > single inc/dec > decay > hold.
- setval[k]: value = SET_VAL; sat_evt[k] = 0 that cycle.
- inc only: value = min(value + step, 2^N-1), computed in N+1 bits, no wrap.
- dec only: value = max(value - step, 0), no wrap.
- sat_evt[k] = 1 on the next cycle iff the requested step exceeded the headroom: value + step > max, or step > value, including when already at the bound. step = 0 gives no change and no sat_evt.
- inc and dec both high: treated as idle (no inc/dec action; decay may apply).
- Prescaler: counts 0..DECAY_DIV-1 while decay_en=1, wraps to 0. tick is asserted internally for the cycle in which count == DECAY_DIV-1. decay_en=0 holds the prescaler at 0 and gives no tick.
- On tick, each idle channel (no setval, not a single inc/dec) moves one count toward REST_VAL; a channel already at REST_VAL holds.
- high[k] is updated on the same edge as value[k], using the new value: set if new >= HI_TH, cleared if new <= LO_TH, otherwise held.
- Latency: one clock from input to value/high/sat_evt. at_max/at_min follow value combinationally.
- Reset mid-operation restores all reset values immediately and restarts the prescaler from 0.

Optional Feature:
SATCNT_BANK_DECAY_EN
- Defined: prescaler and decay logic are present, as described above.
- Undefined: no prescaler is synthesised; decay_en is ignored (port kept); idle channels always hold.

Test Plan:
- Reset release, defaults -> all 4 values = 2, high=0, sat_evt=0, at_min=0, at_max=0.
- ch0 inc with step=5 for one cycle -> value0 = 7 next cycle; other channels remain 2.
- ch1 inc with step=7 held for 37 cycles -> 254 after 36 cycles, then 255 with sat_evt[1]=1 for exactly one cycle. at_max[1]=1. A further inc gives another sat_evt pulse.
- ch2 at 0, dec with step=3 -> stays 0, sat_evt[2]=1. setval with inc asserted on ch2 -> 0, no sat_evt.
- ch3 ramped to 200 -> high[3]=1. dec to 51 -> high still 1. dec to 50 -> high=0. Re-inc to 199 -> high stays 0.
- Decay (macro defined), decay_en=1, ch0 = 7 -> decrements every 16 cycles: 6, 5, 4, 3, 2, then holds at 2. inc&dec asserted on a tick still decays. Assert rst_n low mid-sequence -> all values = 2 and prescaler restarts.

Source files
------------

// File: rtl/saturating_counter_bank.sv
// Multi-channel saturating counter bank with step size, set, hysteresis high flag and clip pulse.
// Optional periodic decay toward REST_VAL is built only when SATCNT_BANK_DECAY_EN is defined.
module saturating_counter_bank #(
    parameter int N           = 8,
    parameter int CH          = 4,
    parameter int STEP_W      = 3,
    parameter int DEFAULT_VAL = 2,
    parameter int SET_VAL     = 0,
    parameter int REST_VAL    = 2,
    parameter int DECAY_DIV   = 16,
    parameter int HI_TH       = 200,
    parameter int LO_TH       = 50
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CH-1:0]     inc,
    input  logic [CH-1:0]     dec,
    input  logic [CH-1:0]     setval,
    input  logic [STEP_W-1:0] step,
    input  logic              decay_en,
    output logic [CH*N-1:0]   value,
    output logic [CH-1:0]     at_max,
    output logic [CH-1:0]     at_min,
    output logic [CH-1:0]     high,
    output logic [CH-1:0]     sat_evt
);

    localparam logic [N-1:0] MAX_V  = '1;
    localparam logic [N-1:0] DEF_V  = N'(DEFAULT_VAL);
    localparam logic [N-1:0] SET_V  = N'(SET_VAL);
    localparam logic [N-1:0] REST_V = N'(REST_VAL);
    localparam logic [N-1:0] HI_V   = N'(HI_TH);
    localparam logic [N-1:0] LO_V   = N'(LO_TH);
    localparam logic         HI_RST = (DEFAULT_VAL >= HI_TH);

    logic tick;

`ifdef SATCNT_BANK_DECAY_EN
    localparam int PS_W = $clog2(DECAY_DIV);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(DECAY_DIV - 1);

    logic [PS_W-1:0] ps_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_cnt <= '0;
        end else if (!decay_en || ps_cnt == PS_LAST) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + 1'b1;
        end
    end

    assign tick = decay_en && (ps_cnt == PS_LAST);
`else
    // Decay disabled: the enable input is kept on the port but has no effect.
    logic unused_decay_en;
    assign unused_decay_en = decay_en;
    assign tick = 1'b0;
`endif

    // Step zero-extended into the N+1-bit headroom arithmetic.
    logic [N:0] step_ext;
    assign step_ext = {{(N + 1 - STEP_W){1'b0}}, step};

    for (genvar k = 0; k < CH; k++) begin : g_ch
        logic [N-1:0] val_r;
        logic [N-1:0] val_nxt;
        logic         high_r;
        logic         high_nxt;
        logic         sat_r;
        logic         sat_nxt;
        logic [N:0]   sum_ext;
        logic         inc_only;
        logic         dec_only;

        assign sum_ext  = {1'b0, val_r} + step_ext;
        assign inc_only = inc[k] & ~dec[k];
        assign dec_only = dec[k] & ~inc[k];

        always_comb begin
            val_nxt = val_r;
            sat_nxt = 1'b0;
            if (setval[k]) begin
                val_nxt = SET_V;
            end else if (inc_only) begin
                if (sum_ext > {1'b0, MAX_V}) begin
                    val_nxt = MAX_V;
                    sat_nxt = 1'b1;
                end else begin
                    val_nxt = sum_ext[N-1:0];
                end
            end else if (dec_only) begin
                if (step_ext > {1'b0, val_r}) begin
                    val_nxt = '0;
                    sat_nxt = 1'b1;
                end else begin
                    val_nxt = val_r - step_ext[N-1:0];
                end
            end else if (tick) begin
                if (val_r > REST_V) begin
                    val_nxt = val_r - 1'b1;
                end else if (val_r < REST_V) begin
                    val_nxt = val_r + 1'b1;
                end
            end
        end

        // Hysteresis evaluated on the value being written this edge.
        always_comb begin
            high_nxt = high_r;
            if (val_nxt >= HI_V) begin
                high_nxt = 1'b1;
            end else if (val_nxt <= LO_V) begin
                high_nxt = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                val_r  <= DEF_V;
                high_r <= HI_RST;
                sat_r  <= 1'b0;
            end else begin
                val_r  <= val_nxt;
                high_r <= high_nxt;
                sat_r  <= sat_nxt;
            end
        end

        assign value[k*N +: N] = val_r;
        assign at_max[k]       = (val_r == MAX_V);
        assign at_min[k]       = (val_r == '0);
        assign high[k]         = high_r;
        assign sat_evt[k]      = sat_r;
    end

endmodule

// File: tb/tb_saturating_counter_bank.sv
// Directed self-checking bench for saturating_counter_bank; decay checks follow SATCNT_BANK_DECAY_EN.
module tb_saturating_counter_bank;

    logic        clk;
    logic        rst_n;
    logic [3:0]  inc;
    logic [3:0]  dec;
    logic [3:0]  setval;
    logic [2:0]  step;
    logic        decay_en;
    logic [31:0] value;
    logic [3:0]  at_max;
    logic [3:0]  at_min;
    logic [3:0]  high;
    logic [3:0]  sat_evt;

    int n_checks = 0;
    int n_fail   = 0;

    saturating_counter_bank dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (inc),
        .dec      (dec),
        .setval   (setval),
        .step     (step),
        .decay_en (decay_en),
        .value    (value),
        .at_max   (at_max),
        .at_min   (at_min),
        .high     (high),
        .sat_evt  (sat_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] v(input int k);
        return value[k*8 +: 8];
    endfunction

    task automatic chk_reset_state(input string tag);
        for (int k = 0; k < 4; k++) chk({tag, "_val"}, v(k), 2);
        chk({tag, "_high"}, high, 0);
        chk({tag, "_sat"}, sat_evt, 0);
        chk({tag, "_at_min"}, at_min, 0);
        chk({tag, "_at_max"}, at_max, 0);
    endtask

    initial begin
        inc = '0; dec = '0; setval = '0; step = '0; decay_en = 1'b0; rst_n = 1'b0;
        cyc(2);
        chk_reset_state("reset");
        rst_n = 1'b1;
        cyc(1);
        chk("post_reset_val0", v(0), 2);

        // ch0 single increment by 5
        inc = 4'b0001; step = 3'd5;
        cyc(1);
        inc = '0;
        chk("ch0_inc5", v(0), 7);
        chk("ch1_untouched", v(1), 2);
        chk("ch2_untouched", v(2), 2);
        chk("ch3_untouched", v(3), 2);
        chk("ch0_no_sat", sat_evt, 0);

        // ch1 ramp to saturation
        inc = 4'b0010; step = 3'd7;
        cyc(36);
        chk("ch1_ramp_254", v(1), 254);
        chk("ch1_no_sat_yet", sat_evt, 0);
        chk("ch1_not_max", at_max[1], 0);
        cyc(1);
        chk("ch1_clip_255", v(1), 255);
        chk("ch1_sat_pulse", sat_evt, 4'b0010);
        chk("ch1_at_max", at_max, 4'b0010);
        chk("ch1_high", high, 4'b0010);
        inc = '0;
        cyc(1);
        chk("ch1_sat_one_cycle", sat_evt, 0);
        chk("ch1_hold_255", v(1), 255);
        inc = 4'b0010;
        cyc(1);
        inc = '0;
        chk("ch1_sat_again", sat_evt, 4'b0010);
        chk("ch1_still_255", v(1), 255);
        cyc(1);
        chk("ch1_sat_clear", sat_evt, 0);

        // ch2 lower bound
        setval = 4'b0100;
        cyc(1);
        setval = '0;
        chk("ch2_set_0", v(2), 0);
        chk("ch2_at_min", at_min, 4'b0100);
        dec = 4'b0100; step = 3'd3;
        cyc(1);
        dec = '0;
        chk("ch2_dec_floor", v(2), 0);
        chk("ch2_sat_low", sat_evt, 4'b0100);
        setval = 4'b0100; inc = 4'b0100;
        cyc(1);
        setval = '0; inc = '0;
        chk("ch2_set_over_inc", v(2), 0);
        chk("ch2_set_no_sat", sat_evt, 0);
        dec = 4'b0100; step = 3'd0;
        cyc(1);
        dec = '0;
        chk("ch2_step0_val", v(2), 0);
        chk("ch2_step0_no_sat", sat_evt, 0);
        inc = 4'b0100; step = 3'd3;
        cyc(1);
        inc = '0;
        chk("ch2_inc3", v(2), 3);

        // ch3 hysteresis
        setval = 4'b1000;
        cyc(1);
        setval = '0;
        inc = 4'b1000; step = 3'd5;
        cyc(39);
        chk("ch3_195", v(3), 195);
        chk("ch3_high_below_th", high[3], 0);
        cyc(1);
        chk("ch3_200", v(3), 200);
        chk("ch3_high_set", high[3], 1);
        inc = '0; dec = 4'b1000; step = 3'd7;
        cyc(21);
        step = 3'd2;
        cyc(1);
        chk("ch3_51", v(3), 51);
        chk("ch3_high_held", high[3], 1);
        step = 3'd1;
        cyc(1);
        chk("ch3_50", v(3), 50);
        chk("ch3_high_clear", high[3], 0);
        dec = '0; inc = 4'b1000; step = 3'd7;
        cyc(21);
        step = 3'd2;
        cyc(1);
        inc = '0;
        chk("ch3_199", v(3), 199);
        chk("ch3_high_stays_low", high[3], 0);

`ifdef SATCNT_BANK_DECAY_EN
        decay_en = 1'b1;
        cyc(15);
        chk("decay_before_tick", v(0), 7);
        cyc(1);
        chk("decay_tick1", v(0), 6);
        chk("decay_up_ch2", v(2), 2);
        for (int e = 5; e >= 2; e--) begin
            cyc(16);
            chk("decay_step", v(0), e);
        end
        cyc(16);
        chk("decay_hold_rest", v(0), 2);
        chk("decay_hold_ch2", v(2), 2);
        chk("decay_ch3", v(3), 193);
        chk("decay_ch1", v(1), 249);
        inc = 4'b1000; dec = 4'b1000;
        cyc(16);
        inc = '0; dec = '0;
        chk("decay_inc_dec_idle", v(3), 192);
        cyc(5);
        rst_n = 1'b0;
        #1;
        chk_reset_state("mid_reset");
        cyc(1);
        rst_n = 1'b1; inc = 4'b0001; step = 3'd5;
        cyc(1);
        inc = '0;
        chk("restart_inc", v(0), 7);
        cyc(14);
        chk("restart_no_early_tick", v(0), 7);
        cyc(1);
        chk("restart_first_tick", v(0), 6);
`else
        decay_en = 1'b1;
        cyc(20);
        chk("no_decay_ch0", v(0), 7);
        chk("no_decay_ch3", v(3), 199);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
